// File: rtl/status_uart_tx.sv
// status_uart_tx
// Sends a snapshot of the CPU status (PC, opcode, ACC, MR, flags, halt) to the
// host as a fixed 9-byte 8N1 packet:
//   A5, pc, opcode, acc_hi, acc_lo, mr_hi, mr_lo, {00,halt,flags}, xor(B1..B7)
// The status inputs are captured once, when a request is accepted in IDLE, so
// later input changes cannot corrupt a packet that is already on the line.
// Bytes follow each other with no idle gap. A one-cycle o_done pulse marks the
// end of the stop bit of the checksum byte.

module status_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868   // 100 MHz / 115200, legal 2..65535
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_send,
    input  logic [7:0]  i_pc,
    input  logic [7:0]  i_opcode,
    input  logic [15:0] i_acc,
    input  logic [15:0] i_mr,
    input  logic [4:0]  i_flags,
    input  logic        i_halt,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [7:0]  HEADER    = 8'hA5;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_BYTE = 4'd8;

    state_t      state_q;
    logic [15:0] baud_q;       // cycles spent in the current bit
    logic [2:0]  bit_idx_q;    // data bit being sent, LSB first
    logic [3:0]  byte_idx_q;   // packet byte being sent, 0..8
    logic [7:0]  shift_q;      // current byte, shifted right as bits go out
    logic [7:0]  xor_q;        // running checksum over B1..B7
    logic [63:0] snap_q;       // B0..B7, B0 in the top byte
    logic        tx_q;
    logic        busy_q;
    logic        done_q;

    logic [3:0]  byte_nxt;
    logic [7:0]  byte_nxt_val;
    logic        baud_last;

    // Select the byte that follows the current one and detect the bit boundary.
    // NOTE: every signal written here gets a value before the case, so no latch is inferred.
    always_comb begin
        byte_nxt     = byte_idx_q + 4'd1;
        baud_last    = (baud_q == BAUD_LAST);
        byte_nxt_val = 8'h00;
        case (byte_nxt[2:0])
            3'd0: byte_nxt_val = snap_q[63:56];
            3'd1: byte_nxt_val = snap_q[55:48];
            3'd2: byte_nxt_val = snap_q[47:40];
            3'd3: byte_nxt_val = snap_q[39:32];
            3'd4: byte_nxt_val = snap_q[31:24];
            3'd5: byte_nxt_val = snap_q[23:16];
            3'd6: byte_nxt_val = snap_q[15:8];
            3'd7: byte_nxt_val = snap_q[7:0];
            default: byte_nxt_val = 8'h00;
        endcase
    end

    // Packet FSM: start bit, 8 data bits LSB first, stop bit, repeated for 9 bytes.
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            xor_q      <= '0;
            snap_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_send) begin
                        snap_q     <= {HEADER, i_pc, i_opcode, i_acc, i_mr,
                                       2'b00, i_halt, i_flags};
                        shift_q    <= HEADER;
                        xor_q      <= '0;
                        byte_idx_q <= '0;
                        bit_idx_q  <= '0;
                        baud_q     <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end

                START: begin
                    if (baud_last) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end

                DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= '0;
                            tx_q      <= 1'b1;
                            state_q   <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end

                STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (byte_idx_q == LAST_BYTE) begin
                            // Line stays high; a held request is taken next edge.
                            byte_idx_q <= '0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            byte_idx_q <= byte_nxt;
                            tx_q       <= 1'b0;
                            state_q    <= START;
                            if (byte_nxt == LAST_BYTE) begin
                                shift_q <= xor_q;
                            end else begin
                                shift_q <= byte_nxt_val;
                                xor_q   <= xor_q ^ byte_nxt_val;
                            end
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule
